score_counter: RTL and testbench
================================

# score_counter

Upstream producer for the per-digit glyph renderers. Holds the running game score as four BCD digits, advances it once every `TICKS_PER_POINT` frame ticks while the game runs, freezes it on game over, and drives each digit's 4-bit value to one renderer instance. Optionally tracks a session high score for a second row of renderers.

## Interface
Parameters:
- `TICKS_PER_POINT`, default 6: frame ticks per score increment; legal range 1..63.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_frame_tick`  in  1  one-cycle pulse, once per frame, issued during vertical blanking.
- `i_game_start`  in  1  one-cycle pulse; starts a new run.
- `i_game_over`  in  1  one-cycle pulse; ends the current run.
- `o_digit0`..`o_digit3`  out  4 each  score digits, BCD; `o_digit0` is the least significant digit.
- `o_running`  out  1  high while in RUN.
- `o_hi_digit0`..`o_hi_digit3`  out  4 each  high-score digits, BCD. Present only with `SCORE_HISCORE_EN`.

## Operation
- All outputs are registered.
- Reset values: all digits 0, `o_running` 0, state IDLE, prescaler 0.
- States:
  - IDLE: score holds at 0000.
  - RUN: counting.
  - OVER: score frozen.
- Transitions:
  - IDLE→RUN on `i_game_start`.
  - RUN→OVER on `i_game_over`.
  - OVER→RUN on `i_game_start`.
  - `i_game_start` is ignored in RUN. `i_game_over` is ignored in IDLE and OVER.
- Entering RUN clears the score to 0000 and the prescaler to 0 in the same edge.
- Prescaler:
  - Width is `$clog2(TICKS_PER_POINT)`, minimum 1.
  - In RUN, each `i_frame_tick` increments it.
  - On a tick when it equals `TICKS_PER_POINT-1`, it returns to 0 and the score increments by 1.
- Score increment is decimal with full carry chain, resolved in one cycle (e.g. 0199→0200).
- 9999 + 1 wraps to 0000 and the run continues.
- Digits never hold values 10–15.
- Simultaneous events:
  - RUN with `i_game_over` and `i_frame_tick` in the same cycle: the over wins, and neither the score nor the prescaler advances.
  - OVER with `i_game_start` and `i_frame_tick` in the same cycle: the score clears, the prescaler is 0, and there is no increment.
- Reset asserted mid-run: immediate return to the reset values, regardless of clock.

## Timing
- Score digits change on the clock edge that samples the qualifying `i_frame_tick`. They are visible one cycle later.
- Since ticks occur in blanking, digits are constant across every active video line. The renderer's one-cycle input register therefore needs no extra alignment.
- `o_running` rises the edge after `i_game_start` and falls the edge after `i_game_over`.
- High score updates one cycle after entering OVER.

## Configuration
- Macro `SCORE_HISCORE_EN`.
- Defined:
  - A 16-bit BCD high-score register exists, reset to 0000, and is not cleared by `i_game_start`.
  - On the first cycle in OVER, if the score is greater than the high score, the high score takes the score. The comparison is plain unsigned on the concatenated digits, which is valid because BCD order matches numeric order.
  - The `o_hi_digit*` ports exist.
- Undefined: the register, the compare, and the ports are absent. Score behaviour is identical in both builds.

## Structure
- Package `score_pkg`:
  - state enum `score_state_t` (IDLE, RUN, OVER);
  - typedef `bcd_digit_t` (4-bit);
  - constant `BCD_MAX` = 9;
  - constant `SCORE_DIGITS` = 4.
- Sub-module `bcd_digit`, instantiated four times, with ports:
  - `clk`, `rst`, `i_clear`, `i_inc` (carry in);
  - `o_value`, `o_carry`: combinational, asserted when `i_inc` and value == 9.
- Top level holds the FSM, the prescaler, the high-score logic, and the carry chain wiring.

## Test plan
- Reset, then `i_game_start`, then 6 ticks (TPP=6) → digits 0001, `o_running`=1; 60 ticks total → 0010.
- Preload the score to 0999 via the count sequence, then one more point → 1000 in a single cycle; from 9999 → 0000 with `o_running` still 1.
- `i_game_over` together with a qualifying tick → score unchanged, state OVER, further ticks ignored.
- Ticks in IDLE and `i_game_over` in IDLE → score stays 0000 and state stays IDLE.
- With `SCORE_HISCORE_EN`:
  - run to 0042, over → hi 0042;
  - restart, reach 0017, over → hi stays 0042 and score shows 0017;
  - restart, reach 0050, over → hi 0050.
- Assert `rst` asynchronously mid-run at score 0123 → all outputs 0 before the next clock edge; hi also 0.

Source files
------------

// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score counter slice.
//   score_state_t : run-state of the game (IDLE, RUN, OVER)
//   bcd_digit_t   : one 4-bit BCD digit
//   BCD_MAX       : largest legal digit value
//   SCORE_DIGITS  : number of digits in the score
package score_pkg;

   localparam int unsigned BCD_W        = 4;
   localparam int unsigned BCD_MAX      = 9;
   localparam int unsigned SCORE_DIGITS = 4;
   localparam int unsigned SCORE_W      = BCD_W * SCORE_DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } score_state_t;

   typedef logic [BCD_W-1:0] bcd_digit_t;

endpackage : score_pkg

// File: rtl/bcd_digit.sv
// bcd_digit: one registered decimal digit with carry out.
//   clk, rst : clock, asynchronous active-high reset
//   i_clear  : synchronous clear to 0 (has priority over i_inc)
//   i_inc    : increment request / carry in from the lower digit
//   o_value  : registered digit value, always 0..9
//   o_carry  : combinational carry out, high when i_inc and value is 9
module bcd_digit
   import score_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clear,
   input  logic       i_inc,
   output bcd_digit_t o_value,
   output logic       o_carry
);

   bcd_digit_t value_q;
   bcd_digit_t value_d;
   logic       at_max;

   assign at_max = (value_q == bcd_digit_t'(BCD_MAX));

   // Next value: clear, else decimal increment wrapping 9 -> 0
   always_comb begin
      value_d = value_q;
      if (i_clear) begin
         value_d = '0;
      end else if (i_inc) begin
         value_d = at_max ? '0 : bcd_digit_t'(value_q + bcd_digit_t'(1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign o_value = value_q;
   assign o_carry = i_inc && at_max;

endmodule : bcd_digit

// File: rtl/score_counter.sv
// score_counter: four-digit BCD game score advanced by frame ticks.
//   Parameter TICKS_PER_POINT (1..63): frame ticks per score point.
//   clk, rst            : clock, asynchronous active-high reset
//   i_frame_tick        : one pulse per frame (vertical blanking)
//   i_game_start        : pulse, starts a new run (IDLE/OVER -> RUN)
//   i_game_over         : pulse, ends the run (RUN -> OVER)
//   o_digit0..o_digit3  : registered score digits, o_digit0 least significant
//   o_running           : registered, high while in RUN
//   o_hi_digit0..3      : registered session high score (SCORE_HISCORE_EN only)
// Build option: define SCORE_HISCORE_EN to add the high-score register and ports.
module score_counter
   import score_pkg::*;
#(
   parameter int unsigned TICKS_PER_POINT = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_frame_tick,
   input  logic       i_game_start,
   input  logic       i_game_over,
   output logic [3:0] o_digit0,
   output logic [3:0] o_digit1,
   output logic [3:0] o_digit2,
   output logic [3:0] o_digit3,
   output logic       o_running
`ifdef SCORE_HISCORE_EN
   ,
   output logic [3:0] o_hi_digit0,
   output logic [3:0] o_hi_digit1,
   output logic [3:0] o_hi_digit2,
   output logic [3:0] o_hi_digit3
`endif
);

   localparam int unsigned PRE_W =
      (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_POINT - 1);

   score_state_t     state_q, state_d;
   logic [PRE_W-1:0] prescale_q, prescale_d;
   logic             running_q, running_d;
   logic             score_clear;
   logic             score_inc;

   bcd_digit_t          digit_value [SCORE_DIGITS];
   logic [SCORE_DIGITS-1:0] digit_inc;
   logic [SCORE_DIGITS-1:0] digit_carry;
   logic                score_wrap_unused;
   logic [SCORE_W-1:0]  score_flat;

   // FSM next state, prescaler and score strobes
   always_comb begin
      state_d     = state_q;
      prescale_d  = prescale_q;
      score_clear = 1'b0;
      score_inc   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_game_start) begin
               state_d     = RUN;
               score_clear = 1'b1;
               prescale_d  = '0;
            end
         end
         RUN: begin
            // game over wins over a coincident tick
            if (i_game_over) begin
               state_d = OVER;
            end else if (i_frame_tick) begin
               if (prescale_q == PRE_LAST) begin
                  prescale_d = '0;
                  score_inc  = 1'b1;
               end else begin
                  prescale_d = PRE_W'(prescale_q + PRE_W'(1));
               end
            end
         end
         OVER: begin
            if (i_game_start) begin
               state_d     = RUN;
               score_clear = 1'b1;
               prescale_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         prescale_q <= '0;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         prescale_q <= prescale_d;
         running_q  <= running_d;
      end
   end

   // Ripple carry chain: each digit's carry out increments the next digit
   assign digit_inc = {digit_carry[SCORE_DIGITS-2:0], score_inc};
   // Carry out of the top digit is dropped so 9999 wraps to 0000
   assign score_wrap_unused = digit_carry[SCORE_DIGITS-1];

   for (genvar g = 0; g < SCORE_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk     (clk),
         .rst     (rst),
         .i_clear (score_clear),
         .i_inc   (digit_inc[g]),
         .o_value (digit_value[g]),
         .o_carry (digit_carry[g])
      );
   end

   assign score_flat = {digit_value[3], digit_value[2], digit_value[1], digit_value[0]};

   assign o_digit0  = digit_value[0];
   assign o_digit1  = digit_value[1];
   assign o_digit2  = digit_value[2];
   assign o_digit3  = digit_value[3];
   assign o_running = running_q;

`ifdef SCORE_HISCORE_EN
   logic [SCORE_W-1:0] hi_q, hi_d;
   logic               over_first_q, over_first_d;

   // BCD digit order matches numeric order, so a plain unsigned compare works
   always_comb begin
      over_first_d = (state_q == RUN) && (state_d == OVER);
      hi_d         = hi_q;
      if (over_first_q && (score_flat > hi_q)) begin
         hi_d = score_flat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q         <= '0;
         over_first_q <= 1'b0;
      end else begin
         hi_q         <= hi_d;
         over_first_q <= over_first_d;
      end
   end

   assign o_hi_digit0 = hi_q[3:0];
   assign o_hi_digit1 = hi_q[7:4];
   assign o_hi_digit2 = hi_q[11:8];
   assign o_hi_digit3 = hi_q[15:12];
`else
   logic [SCORE_W-1:0] score_flat_unused;
   assign score_flat_unused = score_flat;
`endif

endmodule : score_counter

// File: tb/tb_score_counter.sv
// tb_score_counter: randomized and directed stimulus against a behavioural
// score model; expected outputs are queued per cycle and checked by a monitor.
module tb_score_counter;

   localparam int TPP     = 6;
   localparam int ST_IDLE = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_OVER = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_frame_tick = 1'b0;
   logic       i_game_start = 1'b0;
   logic       i_game_over  = 1'b0;
   logic [3:0] o_digit0, o_digit1, o_digit2, o_digit3;
   logic       o_running;
   logic [3:0] o_hi_digit0, o_hi_digit1, o_hi_digit2, o_hi_digit3;

   score_counter #(.TICKS_PER_POINT(TPP)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_frame_tick (i_frame_tick),
      .i_game_start (i_game_start),
      .i_game_over  (i_game_over),
      .o_digit0     (o_digit0),
      .o_digit1     (o_digit1),
      .o_digit2     (o_digit2),
      .o_digit3     (o_digit3),
      .o_running    (o_running)
`ifdef SCORE_HISCORE_EN
      ,
      .o_hi_digit0  (o_hi_digit0),
      .o_hi_digit1  (o_hi_digit1),
      .o_hi_digit2  (o_hi_digit2),
      .o_hi_digit3  (o_hi_digit3)
`endif
   );

`ifndef SCORE_HISCORE_EN
   assign o_hi_digit0 = 4'd0;
   assign o_hi_digit1 = 4'd0;
   assign o_hi_digit2 = 4'd0;
   assign o_hi_digit3 = 4'd0;
`endif

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: plain integers
   int m_st = ST_IDLE;
   int m_score = 0;
   int m_pre = 0;
   int m_hi = 0;
   bit m_over_first = 1'b0;

   typedef struct {
      int          target;
      logic [15:0] score;
      bit          run;
      logic [15:0] hi;
   } exp_t;

   exp_t exp_q[$];

   function automatic logic [15:0] to_bcd(input int n);
      return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic [15:0] dut_score();
      return {o_digit3, o_digit2, o_digit1, o_digit0};
   endfunction

   function automatic logic [15:0] dut_hi();
      return {o_hi_digit3, o_hi_digit2, o_hi_digit1, o_hi_digit0};
   endfunction

   task automatic model_step(input bit s, input bit o, input bit t);
      int prev_st;
      prev_st = m_st;
`ifdef SCORE_HISCORE_EN
      if (m_over_first && m_score > m_hi) m_hi = m_score;
`endif
      if (m_st == ST_RUN) begin
         if (o) m_st = ST_OVER;
         else if (t) begin
            m_pre = m_pre + 1;
            if (m_pre == TPP) begin
               m_pre = 0;
               m_score = (m_score + 1) % 10000;
            end
         end
      end else if (s) begin
         m_st = ST_RUN;
         m_score = 0;
         m_pre = 0;
      end
      m_over_first = (prev_st == ST_RUN) && (m_st == ST_OVER);
   endtask

   task automatic model_reset();
      m_st = ST_IDLE;
      m_score = 0;
      m_pre = 0;
      m_hi = 0;
      m_over_first = 1'b0;
   endtask

   // Drive one cycle of inputs and queue the response of the edge that samples them
   task automatic apply(input bit s, input bit o, input bit t);
      exp_t e;
      @(posedge clk);
      #1;
      i_game_start = s;
      i_game_over  = o;
      i_frame_tick = t;
      model_step(s, o, t);
      e.target = cyc + 1;
      e.score  = to_bcd(m_score);
      e.run    = (m_st == ST_RUN);
      e.hi     = to_bcd(m_hi);
      exp_q.push_back(e);
   endtask

   task automatic points(input int n);
      repeat (n * TPP) apply(1'b0, 1'b0, 1'b1);
   endtask

   // Idle cycle, then check the state produced by the last real stimulus
   task automatic check_now(input string name, input logic [15:0] exp_score, input bit exp_run);
      apply(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (dut_score() !== exp_score || o_running !== exp_run) begin
         bad++;
         $display("FAIL %s: got score=%h running=%b, expected score=%h running=%b",
                  name, dut_score(), o_running, exp_score, exp_run);
      end
   endtask

   task automatic check_hi(input string name, input logic [15:0] exp_hi);
`ifdef SCORE_HISCORE_EN
      // high score lands one cycle after the run ends
      apply(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (dut_hi() !== exp_hi) begin
         bad++;
         $display("FAIL %s: got hi=%h, expected hi=%h", name, dut_hi(), exp_hi);
      end
`else
      if (exp_hi === 16'hxxxx) $display("unused %s", name);
`endif
   endtask

   // Monitor: compare every queued expectation on the falling edge of its cycle
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].target <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         total++;
         if (e.target != cyc || dut_score() !== e.score || o_running !== e.run
`ifdef SCORE_HISCORE_EN
             || dut_hi() !== e.hi
`endif
            ) begin
            bad++;
            $display("FAIL scoreboard cyc=%0d: got score=%h run=%b hi=%h, expected score=%h run=%b hi=%h (target %0d)",
                     cyc, dut_score(), o_running, dut_hi(), e.score, e.run, e.hi, e.target);
         end
      end
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (dut_score() !== 16'h0000 || o_running !== 1'b0 || dut_hi() !== 16'h0000) begin
         bad++;
         $display("FAIL reset_state: got score=%h running=%b hi=%h, expected 0000/0/0000",
                  dut_score(), o_running, dut_hi());
      end
      #1 rst = 1'b0;
      model_reset();

      // IDLE ignores ticks and game over
      for (int i = 0; i < 20; i++) apply(1'b0, (i % 5) == 2, 1'b1);
      check_now("idle_ignore", 16'h0000, 1'b0);

      // Start, first point, tenth point
      apply(1'b1, 1'b0, 1'b0);
      points(1);
      check_now("one_point", 16'h0001, 1'b1);
      points(9);
      check_now("ten_points", 16'h0010, 1'b1);

      // Reach 0042, then game over on a qualifying tick
      points(32);
      repeat (TPP - 1) apply(1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b1, 1'b1);
      repeat (3 * TPP) apply(1'b0, 1'b0, 1'b1);
      check_now("over_with_tick", 16'h0042, 1'b0);
      check_hi("hi_42", 16'h0042);

      // Restart together with a tick: clears, no increment
      apply(1'b1, 1'b0, 1'b1);
      check_now("restart_tick", 16'h0000, 1'b1);
      points(17);
      apply(1'b0, 1'b1, 1'b0);
      check_now("score_17", 16'h0017, 1'b0);
      check_hi("hi_keeps_42", 16'h0042);

      apply(1'b1, 1'b0, 1'b0);
      points(50);
      apply(1'b0, 1'b1, 1'b0);
      check_now("score_50", 16'h0050, 1'b0);
      check_hi("hi_50", 16'h0050);

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         apply($urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
      end
      apply(1'b0, 1'b1, 1'b0);

      // Carry chain and wrap
      apply(1'b1, 1'b0, 1'b0);
      points(999);
      check_now("score_0999", 16'h0999, 1'b1);
      points(1);
      check_now("carry_1000", 16'h1000, 1'b1);
      points(8999);
      check_now("score_9999", 16'h9999, 1'b1);
      points(1);
      check_now("wrap_0000", 16'h0000, 1'b1);

      // Asynchronous reset mid-run at 0123
      apply(1'b0, 1'b1, 1'b0);
      apply(1'b1, 1'b0, 1'b0);
      points(123);
      check_now("score_0123", 16'h0123, 1'b1);
      exp_q.delete();
      #2 rst = 1'b1;
      #1;
      total++;
      if (dut_score() !== 16'h0000 || o_running !== 1'b0 || dut_hi() !== 16'h0000) begin
         bad++;
         $display("FAIL async_reset: got score=%h running=%b hi=%h, expected 0000/0/0000",
                  dut_score(), o_running, dut_hi());
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      apply(1'b0, 1'b0, 1'b1);
      check_now("after_reset_idle", 16'h0000, 1'b0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_score_counter
